period_meter: RTL and testbench
===============================

Name: period_meter

Overview:
- Receive-side counterpart of the team's clock divider: takes a slow periodic signal (divided clock, tick or strobe) and measures its period and high time in `clock` cycles.
- Used for on-board frequency checks, self-test of divider outputs, and monitoring external slow clocks.
- Output is a latched period/high-time pair with a one-cycle valid strobe, plus a timeout flag when no edge arrives.

Parameters:
- WIDTH, 24, width of the cycle counter and result registers. Default covers 1 s at 12 MHz.
- SYNC_STAGES, 2, number of synchronizer flops on `sig_i`. Minimum 2.

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- sig_i  input  1  measured signal; asynchronous to `clock`
- period_o  output  WIDTH  cycles between the last two rising edges
- high_o  output  WIDTH  cycles from the last rising edge to the following falling edge
- valid_o  output  1  one-cycle pulse when `period_o` updates
- timeout_o  output  1  sticky: no rising edge within 2^WIDTH-1 cycles

Behaviour:
- Reset is asynchronous and active-low, on one clock. In reset:
  - synchronizer flops = 0, edge-history flop = 0
  - cnt = 0, state = IDLE
  - period_o = 0, high_o = 0, valid_o = 0, timeout_o = 0
- Synchronization and edge detection:
  - `sig_i` passes through SYNC_STAGES flops giving `s`; a further flop gives `s_d`.
  - rise = s & ~s_d; fall = ~s & s_d.
  - A transition on `sig_i` is detected SYNC_STAGES+1 clocks later.
- State IDLE:
  - cnt held at 0; falls are ignored.
  - On rise: cnt <= 1, go to MEASURE. No valid_o is generated.
- State MEASURE, on rise:
  - period_o <= cnt, cnt <= 1, valid_o <= 1 for the next cycle only.
  - timeout_o <= 0.
  - Example: rises N cycles apart give period_o = N.
- State MEASURE, on fall: high_o <= cnt. `cnt` keeps counting.
- State MEASURE, otherwise: cnt <= cnt+1.
- Timeout: when cnt = 2^WIDTH-1 and no rise occurs that cycle:
  - timeout_o <= 1, state <= IDLE, cnt <= 0.
  - period_o and high_o keep their last values.
- Simultaneous rise and timeout-limit in the same cycle: the rise wins. It is a normal capture with period_o = 2^WIDTH-1.
- rise and fall never coincide, because `s_d` is a single flop.
- Counting is unsigned. There is no wrap-around; the saturation limit triggers the timeout instead.
- valid_o is registered and is never high two cycles in a row.
- If reset_n is asserted mid-measurement, everything returns to the reset values immediately. The first rise after release yields no valid_o.

Optional Feature:
- Macro: PERIOD_METER_AVG_EN
- Defined:
  - Each capture adds cnt into a WIDTH+2-bit accumulator.
  - Every 4th capture: period_o <= acc >> 2 (floor), acc cleared, valid_o pulses.
  - The other three captures produce no valid_o.
  - Timeout or reset clears acc and the capture count.
  - high_o still updates on every fall.
- Undefined: no accumulator logic; every capture produces valid_o as above.

Decomposition:
- period_meter_pkg contains:
  - state enum {IDLE, MEASURE}
  - AVG_SHIFT = 2 and AVG_COUNT = 4 (used only under PERIOD_METER_AVG_EN)
- Sub-module sync_edge:
  - contains the SYNC_STAGES synchronizer, the `s_d` flop, and the rise/fall outputs
  - resettable with reset_n
  - reusable by other asynchronous-input blocks

Test Plan:
- Square wave, `sig_i` high 5 / low 5 cycles, SYNC_STAGES=2, macro undefined:
  - first rise produces no valid_o
  - from the 2nd rise on, valid_o pulses every 10 cycles with period_o=10, high_o=5
  - first valid_o occurs 3+10 cycles after the second `sig_i` rise relative to the first
- Duty 3 high / 7 low -> period_o=10, high_o=3; change to 2 high / 4 low -> next capture gives period_o=6, high_o=2.
- WIDTH=8, one rise then constant low:
  - timeout_o=1 exactly 255 cycles after the detected rise
  - period_o unchanged
  - next two rises 20 apart -> valid_o, period_o=20, timeout_o=0
- Assert reset_n low mid-period:
  - all outputs read 0 during reset
  - after release, the first rise gives no valid_o and the second gives the correct period
- With PERIOD_METER_AVG_EN, periods 10, 10, 12, 12:
  - a single valid_o after the 4th capture, with period_o=11
  - periods 10, 10, 10, 11 -> period_o=10 (floor)

Source files
------------

// File: rtl/period_meter_pkg.sv
// period_meter_pkg
// Shared types and constants for the period_meter block.
//   state_t   : measurement FSM states (IDLE, MEASURE)
//   AVG_SHIFT : right shift applied to the accumulated captures
//   AVG_COUNT : number of captures folded into one averaged result
// AVG_SHIFT / AVG_COUNT are only referenced when PERIOD_METER_AVG_EN is defined.
package period_meter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam int AVG_SHIFT = 2;
  localparam int AVG_COUNT = 4;

endpackage

// File: rtl/period_meter_sync_edge.sv
// period_meter_sync_edge
// Brings an asynchronous 1-bit signal into the clock domain and reports its
// edges. Reusable by any block that watches a slow asynchronous input.
// Ports:
//   clock    : system clock
//   reset_n  : asynchronous active-low reset, clears every flop
//   sig_i    : asynchronous input
//   rise     : one-cycle pulse after a synchronized 0->1 transition
//   fall     : one-cycle pulse after a synchronized 1->0 transition
// Parameter SYNC_STAGES (>= 2) sets the synchronizer depth; an edge on sig_i
// shows up on rise/fall SYNC_STAGES clocks later and is acted on by a
// downstream register one clock after that.
module period_meter_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic sig_i,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;

  // Synchronizer chain plus one history flop for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
      s_d    <= s;
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A single history flop means rise and fall can never be high together.
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/period_meter.sv
// period_meter
// Measures the period and high time of a slow periodic signal in clock cycles.
// Ports:
//   clock     : system clock
//   reset_n   : asynchronous active-low reset
//   sig_i     : measured signal, asynchronous to clock
//   period_o  : cycles between the last two rising edges
//   high_o    : cycles from the last rising edge to the following falling edge
//   valid_o   : one-cycle pulse whenever period_o updates
//   timeout_o : sticky, set when no rising edge arrives within 2^WIDTH-1 cycles;
//               cleared by the next capture
// Parameters: WIDTH (counter/result width), SYNC_STAGES (synchronizer depth, >= 2).
// Optional build macro PERIOD_METER_AVG_EN: period_o reports the floor average
// of every AVG_COUNT captures and valid_o pulses once per group.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int WIDTH       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             sig_i,
  output logic [WIDTH-1:0] period_o,
  output logic [WIDTH-1:0] high_o,
  output logic             valid_o,
  output logic             timeout_o
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic             rise;
  logic             fall;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] period_next;
  logic [WIDTH-1:0] high_next;
  logic             valid_next;
  logic             timeout_next;

`ifdef PERIOD_METER_AVG_EN
  localparam int CAP_W = $clog2(AVG_COUNT);

  logic [WIDTH+AVG_SHIFT-1:0] acc;
  logic [WIDTH+AVG_SHIFT-1:0] acc_next;
  logic [WIDTH+AVG_SHIFT-1:0] acc_sum;
  logic [CAP_W-1:0]           cap_cnt;
  logic [CAP_W-1:0]           cap_cnt_next;
`endif

  period_meter_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .sig_i   (sig_i),
    .rise    (rise),
    .fall    (fall)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      period_o  <= '0;
      high_o    <= '0;
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      period_o  <= period_next;
      high_o    <= high_next;
      valid_o   <= valid_next;
      timeout_o <= timeout_next;
    end
  end

`ifdef PERIOD_METER_AVG_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= '0;
      cap_cnt <= '0;
    end else begin
      acc     <= acc_next;
      cap_cnt <= cap_cnt_next;
    end
  end
`endif

  // cnt equals the number of clocks since the last detected rise, so a rise
  // seen N clocks after the previous one captures exactly N. Reaching CNT_MAX
  // without a rise ends the measurement instead of wrapping; a rise arriving
  // on that same cycle still takes priority as a normal capture.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    period_next  = period_o;
    high_next    = high_o;
    valid_next   = 1'b0;
    timeout_next = timeout_o;
`ifdef PERIOD_METER_AVG_EN
    acc_next     = acc;
    cap_cnt_next = cap_cnt;
    acc_sum      = acc + {{AVG_SHIFT{1'b0}}, cnt};
`endif

    case (state)
      IDLE: begin
        cnt_next = '0;
        if (rise) begin
          cnt_next   = CNT_ONE;
          state_next = MEASURE;
        end
      end

      MEASURE: begin
        if (fall) begin
          high_next = cnt;
        end

        if (rise) begin
          cnt_next     = CNT_ONE;
          timeout_next = 1'b0;
`ifdef PERIOD_METER_AVG_EN
          // Only the last capture of a group publishes; the shift by
          // AVG_SHIFT is the floor divide by AVG_COUNT.
          if (cap_cnt == CAP_W'(AVG_COUNT - 1)) begin
            period_next  = acc_sum[WIDTH+AVG_SHIFT-1:AVG_SHIFT];
            acc_next     = '0;
            cap_cnt_next = '0;
            valid_next   = 1'b1;
          end else begin
            acc_next     = acc_sum;
            cap_cnt_next = cap_cnt + 1'b1;
          end
`else
          period_next = cnt;
          valid_next  = 1'b1;
`endif
        end else if (cnt == CNT_MAX) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
          cnt_next     = '0;
`ifdef PERIOD_METER_AVG_EN
          acc_next     = '0;
          cap_cnt_next = '0;
`endif
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter
// Directed bench for period_meter with WIDTH=8, SYNC_STAGES=2.
// sig_i is driven on falling clock edges; outputs are sampled on falling edges.
module tb_period_meter;

  localparam int WIDTH = 8;

  logic             clock;
  logic             reset_n;
  logic             sig_i;
  logic [WIDTH-1:0] period_o;
  logic [WIDTH-1:0] high_o;
  logic             valid_o;
  logic             timeout_o;

  int assert_count = 0;
  int fail_count   = 0;
  int cycle        = 0;
  int double_count = 0;
  logic prev_valid = 1'b0;
  int valid_log[$];

  int c0;
  int base;

  period_meter #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (2)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .sig_i     (sig_i),
    .period_o  (period_o),
    .high_o    (high_o),
    .valid_o   (valid_o),
    .timeout_o (timeout_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  // Record the cycle of every valid pulse and flag back-to-back pulses.
  always @(negedge clock) begin
    if (valid_o) begin
      valid_log.push_back(cycle);
      if (prev_valid) double_count <= double_count + 1;
    end
    prev_valid <= valid_o;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Square wave: each period starts with a rise; call on a falling edge.
  task automatic applyStimulus(input int high, input int low, input int periods);
    for (int p = 0; p < periods; p++) begin
      sig_i = 1'b1;
      repeat (high) @(negedge clock);
      sig_i = 1'b0;
      repeat (low) @(negedge clock);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    sig_i   = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset_period",  32'(period_o),  0);
    checkOutput("reset_high",    32'(high_o),    0);
    checkOutput("reset_valid",   32'(valid_o),   0);
    checkOutput("reset_timeout", 32'(timeout_o), 0);
    reset_n = 1'b1;

`ifndef PERIOD_METER_AVG_EN
    // 5 high / 5 low: first rise silent, then a capture every 10 cycles.
    c0   = cycle;
    base = valid_log.size();
    applyStimulus(5, 5, 6);
    checkOutput("sq_valid_count", 32'(valid_log.size() - base), 5);
    checkOutput("sq_first_valid_delay", 32'(valid_log[base] - c0), 13);
    checkOutput("sq_valid_spacing", 32'(valid_log[base+4] - valid_log[base]), 40);
    checkOutput("sq_period", 32'(period_o), 10);
    checkOutput("sq_high",   32'(high_o),   5);
    checkOutput("sq_timeout", 32'(timeout_o), 0);

    // Duty change 3/7, then 2/4.
    applyStimulus(3, 7, 3);
    checkOutput("duty37_period", 32'(period_o), 10);
    checkOutput("duty37_high",   32'(high_o),   3);
    applyStimulus(2, 4, 2);
    checkOutput("duty24_period", 32'(period_o), 6);
    checkOutput("duty24_high",   32'(high_o),   2);

    // One more rise, then constant low until the 255-cycle timeout.
    c0    = cycle;
    base  = valid_log.size();
    sig_i = 1'b1;
    repeat (2) @(negedge clock);
    sig_i = 1'b0;
    repeat (255) @(negedge clock);
    checkOutput("timeout_before_limit", 32'(timeout_o), 0);
    @(negedge clock);
    checkOutput("timeout_at_limit", 32'(timeout_o), 1);
    checkOutput("timeout_period_kept", 32'(period_o), 6);
    checkOutput("timeout_high_kept",   32'(high_o),   2);
    checkOutput("timeout_valid_count", 32'(valid_log.size() - base), 1);

    // Recovery from timeout: first rise silent, second rise 20 later captures.
    base = valid_log.size();
    applyStimulus(10, 10, 1);
    checkOutput("recover_timeout_sticky", 32'(timeout_o), 1);
    checkOutput("recover_first_silent", 32'(valid_log.size() - base), 0);
    applyStimulus(10, 10, 1);
    checkOutput("recover_valid_count", 32'(valid_log.size() - base), 1);
    checkOutput("recover_period",  32'(period_o),  20);
    checkOutput("recover_high",    32'(high_o),    10);
    checkOutput("recover_timeout", 32'(timeout_o), 0);

    // Reset asserted mid-measurement.
    sig_i = 1'b1;
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_period",  32'(period_o),  0);
    checkOutput("midreset_high",    32'(high_o),    0);
    checkOutput("midreset_valid",   32'(valid_o),   0);
    checkOutput("midreset_timeout", 32'(timeout_o), 0);
    sig_i = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    base = valid_log.size();
    applyStimulus(4, 4, 1);
    checkOutput("postreset_first_silent", 32'(valid_log.size() - base), 0);
    applyStimulus(4, 4, 2);
    checkOutput("postreset_valid_count", 32'(valid_log.size() - base), 2);
    checkOutput("postreset_period", 32'(period_o), 8);
    checkOutput("postreset_high",   32'(high_o),   4);

    // Rise landing on the same cycle as the counter limit: capture wins.
    applyStimulus(5, 250, 1);
    checkOutput("limit_prev_period",  32'(period_o),  8);
    checkOutput("limit_prev_timeout", 32'(timeout_o), 0);
    base = valid_log.size();
    applyStimulus(5, 5, 1);
    checkOutput("limit_valid_count", 32'(valid_log.size() - base), 1);
    checkOutput("limit_period",  32'(period_o),  255);
    checkOutput("limit_high",    32'(high_o),    5);
    checkOutput("limit_timeout", 32'(timeout_o), 0);
`else
    // Averaging: captures 10,10,12,12 -> 11; then 10,10,10,11 -> floor 10.
    base = valid_log.size();
    applyStimulus(5, 5, 2);
    applyStimulus(5, 7, 2);
    applyStimulus(5, 5, 1);
    checkOutput("avg1_valid_count", 32'(valid_log.size() - base), 1);
    checkOutput("avg1_period", 32'(period_o), 11);
    applyStimulus(5, 5, 2);
    applyStimulus(5, 6, 1);
    applyStimulus(5, 5, 1);
    checkOutput("avg2_valid_count", 32'(valid_log.size() - base), 2);
    checkOutput("avg2_period", 32'(period_o), 10);
    checkOutput("avg2_high",   32'(high_o),   5);
    checkOutput("avg_timeout", 32'(timeout_o), 0);
`endif

    repeat (2) @(negedge clock);
    checkOutput("valid_never_back_to_back", 32'(double_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
